alu_result_buffer: RTL

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: two-entry FIFO that captures ALU results and the flags
// derived from them (zero, carry, negative, {mode, op} tag) at push time.
// Optional build macro ALU_RESULT_BUFFER_STATS_EN adds saturating 8-bit
// counters for accepted pushes and stalled input cycles.
module alu_result_buffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_res,
  input  logic       in_cout,
  input  logic       in_mode,
  input  logic [2:0] in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_res,
  output logic       out_carry,
  output logic       out_zero,
  output logic       out_neg,
  output logic [3:0] out_tag
`ifdef ALU_RESULT_BUFFER_STATS_EN
  ,
  output logic [7:0] stat_pushes,
  output logic [7:0] stat_stalls
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  // Entry layout: [10:7] tag, [6] neg, [5] zero, [4] carry, [3:0] res
  localparam int unsigned EntryW = 11;

  state_e              state_q, state_d;
  logic                wr_ptr_q, rd_ptr_q;
  logic [EntryW-1:0]   mem_q [2];
  logic                armed_q;
  logic                push, pop;
  logic [EntryW-1:0]   new_entry;
  logic [EntryW-1:0]   head;

  // Handshakes; in_ready stays low until the first edge after reset release
  always_comb begin
    in_ready  = armed_q && (state_q != StFull);
    out_valid = (state_q != StEmpty);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Flags are derived here so the consumer never sees logical-mode carry garbage
  always_comb begin
    new_entry = {in_mode, in_op,
                 in_mode & in_res[3],
                 (in_res == 4'b0000),
                 in_mode & in_cout,
                 in_res};
  end

  // Occupancy FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !pop)      state_d = StFull;
        else if (pop && !push) state_d = StEmpty;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // State, pointer and arming registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Entry storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Head outputs are forced to zero whenever nothing is valid
  always_comb begin
    head      = out_valid ? mem_q[rd_ptr_q] : '0;
    out_res   = head[3:0];
    out_carry = head[4];
    out_zero  = head[5];
    out_neg   = head[6];
    out_tag   = head[10:7];
  end

`ifdef ALU_RESULT_BUFFER_STATS_EN
  logic [7:0] push_cnt_q, stall_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt_q  <= 8'd0;
      stall_cnt_q <= 8'd0;
    end else begin
      if (push && (push_cnt_q != 8'hFF)) push_cnt_q <= push_cnt_q + 8'd1;
      if (in_valid && !in_ready && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
    end
  end

  assign stat_pushes = push_cnt_q;
  assign stat_stalls = stall_cnt_q;
`endif

endmodule
